// File: rtl/zion_load_seq_pkg.sv
// Shared types and helpers for the load sequencing controller.
// Access-size encoding, FSM states and the size-in-bytes lookup live here.
package zion_load_seq_pkg;

    typedef enum logic [1:0] {
        ACC_BYTE = 2'd0,
        ACC_HALF = 2'd1,
        ACC_WORD = 2'd2,
        ACC_RSVD = 2'd3
    } acc_type_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ0,
        ST_WAIT0,
        ST_REQ1,
        ST_WAIT1,
        ST_RSP
    } state_t;

    // Reserved type decodes as a full-word access.
    function automatic int unsigned access_size(acc_type_t acc, int unsigned width_data);
        case (acc)
            ACC_BYTE: return 1;
            ACC_HALF: return 2;
            default:  return width_data / 8;
        endcase
    endfunction

endpackage

// File: rtl/zion_load_lane_ext.sv
// Combinational lane extraction: shifts the two-beat window down by the byte
// offset, keeps sz bytes and sign- or zero-fills the rest.
module zion_load_lane_ext
    import zion_load_seq_pkg::*;
#(
    parameter int unsigned WIDTH_DATA = 32,
    parameter int unsigned WIDTH_OFS  = $clog2(WIDTH_DATA / 8)
) (
    input  logic [2*WIDTH_DATA-1:0] merged,
    input  logic [WIDTH_OFS-1:0]    ofs,
    input  logic [WIDTH_OFS:0]      size,
    input  logic                    sign_ext,
    output logic [WIDTH_DATA-1:0]   result
);

    localparam int unsigned NUM_BYTE = WIDTH_DATA / 8;

    logic [WIDTH_DATA-1:0] window;
    logic                  fill;
    int unsigned           size_n;

    always_comb begin
        window = WIDTH_DATA'(merged >> {ofs, 3'b000});
        size_n = 32'(size);
        fill   = 1'b0;
        for (int unsigned i = 0; i < NUM_BYTE; i++) begin
            if (sign_ext && (i + 1 == size_n))
                fill = window[8*i+7];
        end
        result = '0;
        for (int unsigned i = 0; i < NUM_BYTE; i++) begin
            if (i < size_n)
                result[8*i +: 8] = window[8*i +: 8];
            else
                result[8*i +: 8] = {8{fill}};
        end
    end

endmodule

// File: rtl/zion_load_seq_ctrl.sv
// Load sequencing controller: one load in flight, one or two aligned reads,
// merged and extended result on a registered valid/ready response port.
module zion_load_seq_ctrl
    import zion_load_seq_pkg::*;
#(
    parameter int unsigned WIDTH_ADDR = 32,
    parameter int unsigned WIDTH_DATA = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  iReqVld,
    output logic                  oReqRdy,
    input  logic [WIDTH_ADDR-1:0] iReqAddr,
    input  logic [1:0]            iReqType,
    input  logic                  iReqSigned,
    output logic                  oMemVld,
    input  logic                  iMemRdy,
    output logic [WIDTH_ADDR-1:0] oMemAddr,
    input  logic                  iMemRspVld,
    input  logic [WIDTH_DATA-1:0] iMemRspDat,
    output logic                  oRspVld,
    input  logic                  iRspRdy,
    output logic [WIDTH_DATA-1:0] oRspDat
);

    localparam int unsigned NUM_BYTE  = WIDTH_DATA / 8;
    localparam int unsigned WIDTH_OFS = $clog2(NUM_BYTE);
    localparam int unsigned SIZE_W    = WIDTH_OFS + 1;
    localparam logic [WIDTH_ADDR-1:0] WORD_STEP = WIDTH_ADDR'(NUM_BYTE);

    state_t                  state;
    logic [WIDTH_OFS-1:0]    ofs_q;
    acc_type_t               type_q;
    logic                    signed_q;
    logic [WIDTH_DATA-1:0]   beat0;

    logic [2*WIDTH_DATA-1:0] merged;
    logic [WIDTH_DATA-1:0]   ext_dat;
    int unsigned             size_n;
    logic                    split;

    assign oReqRdy = (state == ST_IDLE);

    always_comb begin
        size_n = access_size(type_q, WIDTH_DATA);
        split  = (32'(ofs_q) + size_n) > NUM_BYTE;
    end

    // The result is built from the beat arriving this cycle, so it can be
    // registered on the same edge that enters RSP.
    always_comb begin
        merged = '0;
        if (state == ST_WAIT1)
            merged = {iMemRspDat, beat0};
        else
            merged = {{WIDTH_DATA{1'b0}}, iMemRspDat};
    end

    zion_load_lane_ext #(
        .WIDTH_DATA (WIDTH_DATA),
        .WIDTH_OFS  (WIDTH_OFS)
    ) u_lane_ext (
        .merged   (merged),
        .ofs      (ofs_q),
        .size     (SIZE_W'(size_n)),
        .sign_ext (signed_q),
        .result   (ext_dat)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            ofs_q    <= '0;
            type_q   <= ACC_BYTE;
            signed_q <= 1'b0;
            beat0    <= '0;
            oMemVld  <= 1'b0;
            oMemAddr <= '0;
            oRspVld  <= 1'b0;
            oRspDat  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (iReqVld) begin
                        ofs_q    <= iReqAddr[WIDTH_OFS-1:0];
                        type_q   <= acc_type_t'(iReqType);
                        signed_q <= iReqSigned;
                        oMemVld  <= 1'b1;
                        oMemAddr <= {iReqAddr[WIDTH_ADDR-1:WIDTH_OFS], {WIDTH_OFS{1'b0}}};
                        state    <= ST_REQ0;
                    end
                end
                ST_REQ0: begin
                    if (iMemRdy) begin
                        oMemVld <= 1'b0;
                        state   <= ST_WAIT0;
                    end
                end
                ST_WAIT0: begin
                    if (iMemRspVld) begin
                        beat0 <= iMemRspDat;
                        if (split) begin
                            oMemVld  <= 1'b1;
                            oMemAddr <= oMemAddr + WORD_STEP;
                            state    <= ST_REQ1;
                        end else begin
                            oRspVld <= 1'b1;
                            oRspDat <= ext_dat;
                            state   <= ST_RSP;
                        end
                    end
                end
                ST_REQ1: begin
                    if (iMemRdy) begin
                        oMemVld <= 1'b0;
                        state   <= ST_WAIT1;
                    end
                end
                ST_WAIT1: begin
                    if (iMemRspVld) begin
                        oRspVld <= 1'b1;
                        oRspDat <= ext_dat;
                        state   <= ST_RSP;
                    end
                end
                ST_RSP: begin
                    if (iRspRdy) begin
                        oRspVld <= 1'b0;
                        state   <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
